// File: rtl/mem_read.sv
// mem_read: load unit between the memory stage and the synchronous data RAM.
// Waits the RAM latency, extracts/extends the addressed byte/half/word, flags misaligned loads.
module mem_read #(
    parameter int ADDR_W  = 6,
    parameter int RAM_LAT = 1
) (
    input  logic              clk_dm,
    input  logic              rst_n,
    input  logic              ld_req,
    input  logic [2:0]        ld_type,
    input  logic [31:0]       ld_addr,
    output logic              ld_busy,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic              ld_misalign,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [1:0] LAT_M1 = 2'(RAM_LAT - 1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [2:0]        type_q, type_d;
    logic              mis_q, mis_d;
    logic [31:0]       data_q, data_d;
    logic              req_mis;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       ext;
    logic              unused_addr;

    assign unused_addr = ^ld_addr[31:ADDR_W+2];

    // ld_type[1:0]: 00 byte, 01 half, anything else word; ld_type[2] selects zero-extension
    always_comb begin
        req_mis  = (ld_type[1:0] == 2'b01) ? ld_addr[0] :
                   (ld_type[1:0] == 2'b00) ? 1'b0 : |ld_addr[1:0];
        byte_sel = ram_rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        ext      = (type_q[1:0] == 2'b00) ? {{24{~type_q[2] & byte_sel[7]}}, byte_sel} :
                   (type_q[1:0] == 2'b01) ? {{16{~type_q[2] & half_sel[15]}}, half_sel} :
                   ram_rdata;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        waddr_d = waddr_q;
        type_d  = type_q;
        mis_d   = mis_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (ld_req) begin
                    off_d   = ld_addr[1:0];
                    waddr_d = ld_addr[ADDR_W+1:2];
                    type_d  = ld_type;
                    mis_d   = req_mis;
                    cnt_d   = LAT_M1;
                    data_d  = req_mis ? 32'd0 : data_q;
                    state_d = req_mis ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    data_d  = ext;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_dm) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            off_q   <= 2'd0;
            waddr_q <= '0;
            type_q  <= 3'd0;
            mis_q   <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            type_q  <= type_d;
            mis_q   <= mis_d;
            data_q  <= data_d;
        end
    end

    // Address is held only while the RAM read is in flight; otherwise it tracks the CPU
    assign ram_addr    = (state_q == WAIT) ? waddr_q : ld_addr[ADDR_W+1:2];
    assign ld_busy     = state_q != IDLE;
    assign ld_valid    = state_q == RESP;
    assign ld_misalign = ld_valid & mis_q;
    assign ld_data     = data_q;
endmodule

// File: tb/tb_mem_read.sv
// tb_mem_read: directed vectors for mem_read against a behavioural synchronous RAM.
module tb_mem_read;
    logic        clk_dm = 1'b0;
    logic        rst_n  = 1'b0;
    logic        ld_req = 1'b0;
    logic [2:0]  ld_type = 3'd0;
    logic [31:0] ld_addr = 32'd0;
    logic        sel = 1'b0;

    logic        a_busy, a_valid, a_mis, b_busy, b_valid, b_mis;
    logic [31:0] a_data, b_data, a_rdata, b_rdata;
    logic [5:0]  a_raddr, b_raddr;
    logic        busy, valid, mis;
    logic [31:0] data;
    logic [5:0]  ram_addr;

    logic [31:0] mem [64];
    logic [31:0] b_pipe [3];

    int passed = 0;
    int total  = 0;

    always #5 clk_dm = ~clk_dm;

    mem_read #(.ADDR_W(6), .RAM_LAT(1)) dut_a (
        .clk_dm(clk_dm), .rst_n(rst_n), .ld_req(ld_req & ~sel), .ld_type(ld_type),
        .ld_addr(ld_addr), .ld_busy(a_busy), .ld_valid(a_valid), .ld_data(a_data),
        .ld_misalign(a_mis), .ram_addr(a_raddr), .ram_rdata(a_rdata)
    );

    mem_read #(.ADDR_W(6), .RAM_LAT(3)) dut_b (
        .clk_dm(clk_dm), .rst_n(rst_n), .ld_req(ld_req & sel), .ld_type(ld_type),
        .ld_addr(ld_addr), .ld_busy(b_busy), .ld_valid(b_valid), .ld_data(b_data),
        .ld_misalign(b_mis), .ram_addr(b_raddr), .ram_rdata(b_rdata)
    );

    always @(posedge clk_dm) begin
        a_rdata   <= mem[a_raddr];
        b_pipe[0] <= mem[b_raddr];
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_rdata = b_pipe[2];

    assign busy     = sel ? b_busy  : a_busy;
    assign valid    = sel ? b_valid : a_valid;
    assign mis      = sel ? b_mis   : a_mis;
    assign data     = sel ? b_data  : a_data;
    assign ram_addr = sel ? b_raddr : a_raddr;

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
        logic        mis;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic do_load(input logic s, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] ed, input logic em, input int el);
        int k;
        logic [31:0] na;
        na = ~a;
        @(posedge clk_dm); #1;
        sel = s; ld_req = 1'b1; ld_type = t; ld_addr = a;
        @(posedge clk_dm); #1;
        ld_req = 1'b0; ld_addr = na;
        #1;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("ram_addr", 32'(ram_addr), em ? 32'(na[7:2]) : 32'(a[7:2]));
        k = 1;
        while (!valid && k < 20) begin
            @(posedge clk_dm); #1;
            k++;
        end
        chk("latency", k, el);
        chk("ld_data", data, ed);
        chk("ld_misalign", 32'(mis), 32'(em));
        @(posedge clk_dm); #1;
        chk("valid_pulse", 32'(valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("data_hold", data, ed);
    endtask

    initial begin
        int nv;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i) * 32'h01010101;
        mem[3]  = 32'h8081F0F7;
        mem[5]  = 32'h7F001234;
        mem[63] = 32'hDEADBEEF;

        vecs[0]  = '{3'b000, 32'h0D,  32'hFFFFFFF0, 1'b0};
        vecs[1]  = '{3'b100, 32'h0F,  32'h00000080, 1'b0};
        vecs[2]  = '{3'b001, 32'h0E,  32'hFFFF8081, 1'b0};
        vecs[3]  = '{3'b101, 32'h0C,  32'h0000F0F7, 1'b0};
        vecs[4]  = '{3'b010, 32'h0C,  32'h8081F0F7, 1'b0};
        vecs[5]  = '{3'b010, 32'h10C, 32'h8081F0F7, 1'b0};
        vecs[6]  = '{3'b010, 32'h0E,  32'h00000000, 1'b1};
        vecs[7]  = '{3'b001, 32'h05,  32'h00000000, 1'b1};
        vecs[8]  = '{3'b000, 32'h17,  32'h0000007F, 1'b0};
        vecs[9]  = '{3'b001, 32'h14,  32'h00001234, 1'b0};
        vecs[10] = '{3'b011, 32'h14,  32'h7F001234, 1'b0};
        vecs[11] = '{3'b011, 32'h15,  32'h00000000, 1'b1};
        vecs[12] = '{3'b101, 32'hFE,  32'h0000DEAD, 1'b0};
        vecs[13] = '{3'b001, 32'hFE,  32'hFFFFDEAD, 1'b0};
        vecs[14] = '{3'b100, 32'hFC,  32'h000000EF, 1'b0};
        vecs[15] = '{3'b101, 32'h0F,  32'h00000000, 1'b1};

        repeat (3) @(posedge clk_dm);
        #1;
        rst_n = 1'b1;
        chk("rst_busy_a", 32'(a_busy), 32'd0);
        chk("rst_valid_a", 32'(a_valid), 32'd0);
        chk("rst_data_a", a_data, 32'd0);
        chk("rst_mis_a", 32'(a_mis), 32'd0);
        chk("rst_busy_b", 32'(b_busy), 32'd0);
        chk("rst_data_b", b_data, 32'd0);

        for (int i = 0; i < 16; i++)
            do_load(1'b0, vecs[i].typ, vecs[i].addr, vecs[i].data, vecs[i].mis,
                    vecs[i].mis ? 1 : 2);

        // request held through WAIT and RESP must yield a single response
        @(posedge clk_dm); #1;
        sel = 1'b0; ld_req = 1'b1; ld_type = 3'b000; ld_addr = 32'h0D;
        nv = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_dm); #1;
            if (k == 3) ld_req = 1'b0;
            if (valid) nv++;
        end
        chk("busy_ignore_count", nv, 1);
        do_load(1'b0, 3'b010, 32'h14, 32'h7F001234, 1'b0, 2);

        // reset wins over a simultaneous request
        @(posedge clk_dm); #1;
        rst_n = 1'b0; ld_req = 1'b1; ld_type = 3'b010; ld_addr = 32'h0C;
        @(posedge clk_dm); #1;
        rst_n = 1'b1; ld_req = 1'b0;
        chk("rst_req_busy", 32'(a_busy), 32'd0);
        chk("rst_req_data", a_data, 32'd0);
        nv = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_dm); #1;
            if (a_valid) nv++;
        end
        chk("rst_req_no_valid", nv, 0);

        do_load(1'b1, 3'b010, 32'h0E, 32'h00000000, 1'b1, 1);
        do_load(1'b1, 3'b010, 32'h0C, 32'h8081F0F7, 1'b0, 4);
        do_load(1'b1, 3'b000, 32'h0D, 32'hFFFFFFF0, 1'b0, 4);

        // reset during WAIT drops the in-flight load
        @(posedge clk_dm); #1;
        sel = 1'b1; ld_req = 1'b1; ld_type = 3'b010; ld_addr = 32'h14;
        @(posedge clk_dm); #1;
        ld_req = 1'b0;
        chk("wait_busy", 32'(b_busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk_dm); #1;
        rst_n = 1'b1;
        chk("rst_wait_busy", 32'(b_busy), 32'd0);
        chk("rst_wait_valid", 32'(b_valid), 32'd0);
        chk("rst_wait_data", b_data, 32'd0);
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_dm); #1;
            if (b_valid) nv++;
        end
        chk("rst_wait_no_valid", nv, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_read.md
Name: mem_read

Overview:
- Load unit on the read side of the data memory.
- Accepts a load request from the CPU, drives the word address into the synchronous data RAM and waits the RAM read latency.
- Extracts and sign- or zero-extends the addressed byte, halfword or word, then returns it with a one-cycle valid pulse.
- Flags misaligned accesses without touching the RAM. Sits between the execute/memory stage and the 64-word data RAM.

Parameters:
- ADDR_W, 6: RAM word-address width. Word index is ld_addr[ADDR_W+1:2].
- RAM_LAT, 1: RAM read latency in cycles, from address sampled to douta valid. Legal values 1..3.

Ports:
- clk_dm  input  1  clock; all logic on the rising edge
- rst_n  input  1  synchronous active-low reset
- ld_req  input  1  load request; sampled only in IDLE
- ld_type  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other code is treated as LW
- ld_addr  input  32  byte address
- ld_busy  output  1  high whenever state is not IDLE
- ld_valid  output  1  one-cycle pulse; ld_data and ld_misalign are valid in this cycle
- ld_data  output  32  extended load result
- ld_misalign  output  1  qualifies ld_valid; access was misaligned and ld_data=0
- ram_addr  output  ADDR_W  word address to the RAM addra
- ram_rdata  input  32  RAM douta

Behaviour:
Reset (rst_n low at a rising edge):
- state=IDLE; ld_busy=0, ld_valid=0, ld_data=0, ld_misalign=0; wait counter=0.
- Any in-flight load is discarded; no ld_valid is issued for it.

States: IDLE, WAIT, RESP.

IDLE:
- ram_addr = ld_addr[ADDR_W+1:2], combinationally.
- On ld_req=1 at an edge: capture ld_addr[1:0], ld_addr[ADDR_W+1:2] and ld_type.
- Misaligned (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0): go to RESP with misalign flag set.
- Otherwise go to WAIT with counter=RAM_LAT-1.

WAIT:
- ram_addr = captured word address (held stable).
- Counter decrements each cycle.
- At the edge where counter==0: capture ram_rdata, extract/extend into ld_data, go to RESP.

RESP:
- ld_valid=1 for exactly this cycle; ld_misalign=1 if the misalign flag is set (then ld_data=0).
- Return to IDLE at the next edge.
- ld_busy is high in RESP. A new request is taken only from IDLE, so back-to-back loads are spaced RAM_LAT+2 cycles apart.

Latency, with the request accepted at edge N:
- Aligned: ld_valid high during cycle N+RAM_LAT+1.
- Misaligned: ld_valid high during cycle N+1.

Extraction (little-endian; byte k = ram_rdata[8k+7:8k], k = addr[1:0]):
- LB: sign-extend byte k. LBU: zero-extend byte k.
- LH: sign-extend the halfword at addr[1] (0 gives bits 15:0, 1 gives bits 31:16). LHU: zero-extend the same halfword.
- LW: ram_rdata unchanged.

Boundary conditions:
- ld_addr bits above ADDR_W+1 are ignored; addresses wrap modulo 4*2^ADDR_W bytes.
- ld_req while ld_busy=1 is ignored entirely; it is not queued.
- ld_data holds its last value until the next ld_valid. On a misaligned access it is written 0.
- ld_req in IDLE in the same cycle as rst_n=0: reset wins and the request is dropped.
- ram_rdata is sampled only at the WAIT capture edge; changes at any other time have no effect.

Test Plan:
- Preload RAM word 3 = 0x8081F0F7, RAM_LAT=1. LB at 0x0D accepted at edge N -> ld_valid in cycle N+2, ld_data=0xFFFFFFF0, ld_misalign=0, ram_addr=3 while busy.
- Same word: LBU 0x0F -> 0x00000080; LH 0x0E -> 0xFFFF8081; LHU 0x0C -> 0x0000F0F7; LW 0x0C -> 0x8081F0F7.
- Wrap: LW at 0x0000010C -> ram_addr=3, ld_data=0x8081F0F7.
- Misaligned LW at 0x0E and LH at 0x05 -> ld_valid in cycle N+1 with ld_misalign=1 and ld_data=0; ram_addr never leaves IDLE tracking.
- Second ld_req held high during WAIT and RESP -> ignored, exactly one ld_valid. Re-assert in IDLE -> accepted.
- RAM_LAT=3 -> ld_valid in cycle N+4. rst_n low in WAIT -> no ld_valid afterwards, ld_data=0, ld_busy=0 on the next cycle.
